// File: rtl/lut_loader.sv
// lut_loader: DI-bus initiator that writes a clamped linear tone curve into the lookup-map terminal.
// Define LUT_LOADER_VERIFY_EN to add a per-entry read-back check after the write pass.
`ifndef TERM_LookupMap
`define TERM_LookupMap 16'h0040
`endif

module lut_loader #(
  parameter int          PIXEL_WIDTH   = 8,
  parameter int          DI_DATA_WIDTH = 16,
  parameter int          NUM_ENTRIES   = 1024,
  parameter logic [15:0] TERM_ADDR     = `TERM_LookupMap,
  parameter int          TIMEOUT       = 255
) (
  input  logic                     di_clk,
  input  logic                     resetb,
  input  logic                     start,
  input  logic [11:0]              gain,
  input  logic [PIXEL_WIDTH:0]     offset,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [10:0]              mismatch_count,
  output logic [15:0]              di_term_addr,
  output logic [31:0]              di_reg_addr,
  output logic                     di_write_mode,
  output logic                     di_write,
  output logic                     di_read_mode,
  output logic                     di_read_req,
  output logic                     di_read,
  output logic [DI_DATA_WIDTH-1:0] di_reg_datai,
  input  logic                     di_write_rdy,
  input  logic                     di_read_rdy,
  input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,
  input  logic [15:0]              di_transfer_status
);

  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int ACC_W  = 22;
  localparam int V_W    = (PIXEL_WIDTH + 2 > 23) ? PIXEL_WIDTH + 2 : 23;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [V_W-1:0] PIX_MAX  = V_W'((1 << PIXEL_WIDTH) - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_WRITE, S_WSTEP,
`ifdef LUT_LOADER_VERIFY_EN
    S_RSETUP, S_RREQ, S_RWAIT,
`endif
    S_FINISH, S_ERR
  } state_t;

  // Entry = clamp((acc >> 8) + offset); only the integer part of acc is passed in.
  function automatic logic [PIXEL_WIDTH-1:0] entry_of(input logic [ACC_W-9:0] a_hi,
                                                       input logic [PIXEL_WIDTH:0] ofs);
    logic signed [V_W-1:0] v;
    v = $signed({{(V_W-ACC_W+8){1'b0}}, a_hi}) +
        $signed({{(V_W-PIXEL_WIDTH-1){ofs[PIXEL_WIDTH]}}, ofs});
    if (v[V_W-1])         entry_of = '0;
    else if (v > PIX_MAX) entry_of = '1;
    else                  entry_of = v[PIXEL_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] addr_of(input logic [IDX_W-1:0] i);
    addr_of = {{(32-IDX_W){1'b0}}, i};
  endfunction

  function automatic logic [DI_DATA_WIDTH-1:0] data_of(input logic [PIXEL_WIDTH-1:0] e);
    data_of = {{(DI_DATA_WIDTH-PIXEL_WIDTH){1'b0}}, e};
  endfunction

  state_t                   state_reg, state_next;
  logic [WAIT_W-1:0]        wait_reg, wait_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [ACC_W-1:0]         acc_reg, acc_next;
  logic [11:0]              gain_reg, gain_next;
  logic [PIXEL_WIDTH:0]     ofs_reg, ofs_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     error_reg, error_next;
  logic [15:0]              term_reg, term_next;
  logic [31:0]              addr_reg, addr_next;
  logic [DI_DATA_WIDTH-1:0] datai_reg, datai_next;
  logic                     wmode_reg, wmode_next;
  logic                     write_reg, write_next;
`ifdef LUT_LOADER_VERIFY_EN
  logic                     rmode_reg, rmode_next;
  logic                     rreq_reg, rreq_next;
  logic                     read_reg, read_next;
  logic [10:0]              mism_reg, mism_next;
`endif

  logic [IDX_W-1:0]       idx_inc;
  logic [ACC_W-1:0]       acc_inc;
  logic [PIXEL_WIDTH-1:0] cur_entry, inc_entry;
  logic                   unused_inputs;

  assign idx_inc       = idx_reg + IDX_W'(1);
  assign acc_inc       = acc_reg + ACC_W'(gain_reg);
  assign cur_entry     = entry_of(acc_reg[ACC_W-1:8], ofs_reg);
  assign inc_entry     = entry_of(acc_inc[ACC_W-1:8], ofs_reg);
  assign unused_inputs = ^{di_read_rdy, di_reg_datao};

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    gain_next  = gain_reg;
    ofs_next   = ofs_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    error_next = error_reg;
    term_next  = term_reg;
    addr_next  = addr_reg;
    datai_next = datai_reg;
    wmode_next = wmode_reg;
    write_next = 1'b0;
`ifdef LUT_LOADER_VERIFY_EN
    rmode_next = rmode_reg;
    rreq_next  = 1'b0;
    read_next  = 1'b0;
    mism_next  = mism_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        // busy is still high during the done cycle, so a start there is ignored
        if (start && !busy_reg) begin
          state_next = S_SETUP;
          gain_next  = gain;
          ofs_next   = offset;
          idx_next   = '0;
          acc_next   = '0;
          error_next = 1'b0;
          busy_next  = 1'b1;
          term_next  = TERM_ADDR;
          wmode_next = 1'b1;
`ifdef LUT_LOADER_VERIFY_EN
          mism_next  = '0;
`endif
        end
      end
      S_SETUP: begin
        wait_next = wait_reg + WAIT_W'(1);
        if (wait_reg != '0) begin
          if (di_transfer_status != '0) begin
            state_next = S_ERR;
          end else begin
            state_next = S_WRITE;
            addr_next  = addr_of(idx_reg);
            datai_next = data_of(cur_entry);
          end
        end
      end
      S_WRITE: begin
        if (di_write_rdy) begin
          write_next = 1'b1;
          state_next = S_WSTEP;
        end else if (wait_reg == WAIT_W'(TIMEOUT)) begin
          state_next = S_ERR;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      S_WSTEP: begin
        if (idx_reg == LAST_IDX) begin
`ifdef LUT_LOADER_VERIFY_EN
          state_next = S_RSETUP;
          idx_next   = '0;
          acc_next   = '0;
          addr_next  = '0;
          wmode_next = 1'b0;
          rmode_next = 1'b1;
`else
          state_next = S_FINISH;
`endif
        end else begin
          // Next address/data go out now so they are settled a cycle before the strobe.
          state_next = S_WRITE;
          idx_next   = idx_inc;
          acc_next   = acc_inc;
          addr_next  = addr_of(idx_inc);
          datai_next = data_of(inc_entry);
        end
      end
`ifdef LUT_LOADER_VERIFY_EN
      S_RSETUP: begin
        wait_next = wait_reg + WAIT_W'(1);
        if (wait_reg != '0) begin
          state_next = S_RREQ;
          rreq_next  = 1'b1;
        end
      end
      S_RREQ: state_next = S_RWAIT;
      S_RWAIT: begin
        if (di_read_rdy) begin
          read_next = 1'b1;
          if (di_reg_datao[PIXEL_WIDTH-1:0] != cur_entry && mism_reg != '1)
            mism_next = mism_reg + 11'd1;
          if (idx_reg == LAST_IDX) begin
            state_next = S_FINISH;
          end else begin
            state_next = S_RSETUP;
            idx_next   = idx_inc;
            acc_next   = acc_inc;
            addr_next  = addr_of(idx_inc);
          end
        end else if (wait_reg == WAIT_W'(TIMEOUT)) begin
          state_next = S_ERR;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
`endif
      S_FINISH: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
        term_next  = '0;
        addr_next  = '0;
        datai_next = '0;
        wmode_next = 1'b0;
`ifdef LUT_LOADER_VERIFY_EN
        rmode_next = 1'b0;
`endif
      end
      S_ERR: begin
        state_next = S_IDLE;
        error_next = 1'b1;
        busy_next  = 1'b0;
        term_next  = '0;
        addr_next  = '0;
        datai_next = '0;
        wmode_next = 1'b0;
`ifdef LUT_LOADER_VERIFY_EN
        rmode_next = 1'b0;
`endif
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next != state_reg)
      wait_next = '0;
  end

  always_ff @(posedge di_clk or negedge resetb) begin
    if (!resetb) begin
      state_reg <= S_IDLE;
      wait_reg  <= '0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      gain_reg  <= '0;
      ofs_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      term_reg  <= '0;
      addr_reg  <= '0;
      datai_reg <= '0;
      wmode_reg <= 1'b0;
      write_reg <= 1'b0;
`ifdef LUT_LOADER_VERIFY_EN
      rmode_reg <= 1'b0;
      rreq_reg  <= 1'b0;
      read_reg  <= 1'b0;
      mism_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      gain_reg  <= gain_next;
      ofs_reg   <= ofs_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      term_reg  <= term_next;
      addr_reg  <= addr_next;
      datai_reg <= datai_next;
      wmode_reg <= wmode_next;
      write_reg <= write_next;
`ifdef LUT_LOADER_VERIFY_EN
      rmode_reg <= rmode_next;
      rreq_reg  <= rreq_next;
      read_reg  <= read_next;
      mism_reg  <= mism_next;
`endif
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign di_term_addr  = term_reg;
  assign di_reg_addr   = addr_reg;
  assign di_reg_datai  = datai_reg;
  assign di_write_mode = wmode_reg;
  assign di_write      = write_reg;
`ifdef LUT_LOADER_VERIFY_EN
  assign di_read_mode   = rmode_reg;
  assign di_read_req    = rreq_reg;
  assign di_read        = read_reg;
  assign mismatch_count = mism_reg;
`else
  assign di_read_mode   = 1'b0;
  assign di_read_req    = 1'b0;
  assign di_read        = 1'b0;
  assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader: DI responder with a table memory, hand-computed entries and timing.
module tb_lut_loader;
  localparam logic [15:0] TERM = 16'h00A5;
`ifdef LUT_LOADER_VERIFY_EN
  localparam int DONE_AT = 6147;
`else
  localparam int DONE_AT = 2051;
`endif

  logic        di_clk, resetb, start;
  logic [11:0] gain;
  logic [8:0]  offset;
  logic        busy, done, error;
  logic [10:0] mismatch_count;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic        di_write_mode, di_write, di_read_mode, di_read_req, di_read;
  logic [15:0] di_reg_datai;
  logic        di_write_rdy, di_read_rdy;
  logic [15:0] di_reg_datao;
  logic [15:0] di_transfer_status;

  int n_total, n_bad, cyc, wr_count, done_count, first_wr, done_cyc, err_cyc, corrupt_idx;
  logic [31:0] prev_addr;
  logic [15:0] prev_datai;
  logic [7:0]  mem [0:1023];

  lut_loader #(
    .PIXEL_WIDTH(8), .DI_DATA_WIDTH(16), .NUM_ENTRIES(1024), .TERM_ADDR(TERM), .TIMEOUT(255)
  ) dut (
    .di_clk(di_clk), .resetb(resetb), .start(start), .gain(gain), .offset(offset),
    .busy(busy), .done(done), .error(error), .mismatch_count(mismatch_count),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_write_mode(di_write_mode), .di_write(di_write),
    .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
    .di_reg_datai(di_reg_datai), .di_write_rdy(di_write_rdy), .di_read_rdy(di_read_rdy),
    .di_reg_datao(di_reg_datao), .di_transfer_status(di_transfer_status)
  );

  initial di_clk = 1'b0;
  always #5 di_clk = ~di_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{busy, done, error, mismatch_count, di_term_addr, di_reg_addr, di_write_mode,
             di_write, di_read_mode, di_read_req, di_read, di_reg_datai};
  endfunction

  // One cycle: observe on the falling edge, record writes, then act as the read responder.
  task automatic tick();
    @(negedge di_clk);
    cyc++;
    if (di_write) begin
      check("addr_stable", di_reg_addr, prev_addr);
      check("data_stable", 32'(di_reg_datai), 32'(prev_datai));
      mem[di_reg_addr[9:0]] = di_reg_datai[7:0];
      wr_count++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (done) begin
      done_count++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (error && err_cyc < 0) err_cyc = cyc;
    prev_addr  = di_reg_addr;
    prev_datai = di_reg_datai;
    if (di_read) begin
      di_read_rdy = 1'b0;
    end else if (di_read_req) begin
      di_read_rdy  = 1'b1;
      di_reg_datao = {8'h00, mem[di_reg_addr[9:0]] ^ ((int'(di_reg_addr) == corrupt_idx) ? 8'h01 : 8'h00)};
    end
  endtask

  task automatic run_load(input logic [11:0] g, input logic [8:0] o, input int max_cyc,
                          input int poke_at, input int rst_at);
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    gain = g; offset = o;
    wr_count = 0; done_count = 0; first_wr = -1; done_cyc = -1; err_cyc = -1;
    start = 1'b1;
    cyc = -1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("term_after_start", 32'(di_term_addr), 32'(TERM));
    check("wmode_after_start", 32'(di_write_mode), 32'd1);
    check("err_clear_on_start", 32'(error), 32'd0);
    while (done_cyc < 0 && err_cyc < 0 && cyc < max_cyc) begin
      start = (cyc == poke_at);
      tick();
      start = 1'b0;
      if (rst_at >= 0 && wr_count == rst_at) begin
        resetb = 1'b0;
        tick();
        check("rst_midload_outs", 32'(any_out()), 32'd0);
        resetb = 1'b1;
        tick();
        return;
      end
    end
    repeat (4) tick();
  endtask

  initial begin
    n_total = 0; n_bad = 0; cyc = 0; corrupt_idx = -1;
    prev_addr = '0; prev_datai = '0;
    resetb = 1'b0; start = 1'b0; gain = '0; offset = '0;
    di_write_rdy = 1'b1; di_read_rdy = 1'b0; di_reg_datao = '0; di_transfer_status = '0;
    repeat (3) tick();
    check("reset_outs", 32'(any_out()), 32'd0);
    resetb = 1'b1;
    repeat (2) tick();

    // identity slope, with a start pulse while busy that must be ignored
    run_load(12'h100, 9'd0, 12000, 100, -1);
    check("a_first_write", 32'(first_wr), 32'd3);
    check("a_done_cycle", 32'(done_cyc), 32'(DONE_AT));
    check("a_writes", 32'(wr_count), 32'd1024);
    check("a_done_once", 32'(done_count), 32'd1);
    check("a_error", 32'(error), 32'd0);
    check("a_mismatch", 32'(mismatch_count), 32'd0);
    check("a_busy_low", 32'(busy), 32'd0);
    check("a_term_low", 32'(di_term_addr), 32'd0);
    check("a_e0", 32'(mem[0]), 32'd0);
    check("a_e1", 32'(mem[1]), 32'd1);
    check("a_e200", 32'(mem[200]), 32'd200);
    check("a_e255", 32'(mem[255]), 32'd255);
    check("a_e256", 32'(mem[256]), 32'd255);
    check("a_e1023", 32'(mem[1023]), 32'd255);

    // half slope, positive offset
    run_load(12'h080, 9'd10, 12000, -1, -1);
    check("b_e0", 32'(mem[0]), 32'd10);
    check("b_e100", 32'(mem[100]), 32'd60);
    check("b_e489", 32'(mem[489]), 32'd254);
    check("b_e490", 32'(mem[490]), 32'd255);
    check("b_e1023", 32'(mem[1023]), 32'd255);
    check("b_done_once", 32'(done_count), 32'd1);

    // terminal absent during setup
    di_transfer_status = 16'h0004;
    run_load(12'h100, 9'd0, 50, -1, -1);
    di_transfer_status = '0;
    check("st_err_window", 32'(err_cyc >= 2 && err_cyc <= 6), 32'd1);
    check("st_error", 32'(error), 32'd1);
    check("st_no_writes", 32'(wr_count), 32'd0);
    check("st_no_done", 32'(done_count), 32'd0);
    check("st_busy_low", 32'(busy), 32'd0);

    // responder never ready: timeout in WRITE
    di_write_rdy = 1'b0;
    run_load(12'h100, 9'd0, 400, -1, -1);
    di_write_rdy = 1'b1;
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_window", 32'(err_cyc >= 255 && err_cyc <= 265), 32'd1);
    check("tmo_no_done", 32'(done_count), 32'd0);
    check("tmo_di_idle", 32'(|{di_term_addr, di_reg_addr, di_write_mode, di_write, di_reg_datai}), 32'd0);
    check("tmo_busy_low", 32'(busy), 32'd0);

    // negative offset clamps low end to zero
    run_load(12'h100, 9'h1EC, 12000, -1, -1);
    check("c_e0", 32'(mem[0]), 32'd0);
    check("c_e20", 32'(mem[20]), 32'd0);
    check("c_e21", 32'(mem[21]), 32'd1);
    check("c_e274", 32'(mem[274]), 32'd254);
    check("c_e275", 32'(mem[275]), 32'd255);
    check("c_error", 32'(error), 32'd0);
    check("c_done_once", 32'(done_count), 32'd1);

`ifdef LUT_LOADER_VERIFY_EN
    corrupt_idx = 7;
    run_load(12'h100, 9'd0, 12000, -1, -1);
    corrupt_idx = -1;
    check("v_mismatch", 32'(mismatch_count), 32'd1);
    check("v_done_once", 32'(done_count), 32'd1);
    check("v_error", 32'(error), 32'd0);
`endif

    // reset partway through, then a clean load
    run_load(12'h100, 9'd0, 12000, -1, 500);
    check("r_partial_writes", 32'(wr_count), 32'd500);
    run_load(12'h080, 9'd10, 12000, -1, -1);
    check("r_done_cycle", 32'(done_cyc), 32'(DONE_AT));
    check("r_done_once", 32'(done_count), 32'd1);
    check("r_writes", 32'(wr_count), 32'd1024);
    check("r_e100", 32'(mem[100]), 32'd60);
    check("r_error", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
